// File: rtl/srio_sup_pkg.sv
// Shared definitions for the SRIO link supervisor: FSM state codes, counter widths and a width helper.
package srio_sup_pkg;

    localparam int RETRY_W    = 4;
    localparam int DROP_CNT_W = 8;

    localparam logic [2:0] S_OFF  = 3'd0;
    localparam logic [2:0] S_RST  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_UP   = 3'd3;
    localparam logic [2:0] S_FAIL = 3'd4;

    typedef logic [2:0] sup_state_t;

    // Ceiling log2, floored at 1 so a counter never collapses to zero width.
    function automatic int clog2(input int value);
        int width;
        width = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                width = i + 1;
            end
        end
        return (width < 1) ? 1 : width;
    endfunction

endpackage

// File: rtl/srio_link_sup_ch.sv
// One SRIO channel: status synchronizers, bring-up/recovery FSM and its timers.
// Optional SRIO_SUP_STATS_EN adds a saturating count of filtered link drops.
module srio_link_sup_ch
    import srio_sup_pkg::*;
#(
    parameter int RST_HOLD     = 64,
    parameter int LINK_TIMEOUT = 50000000,
    parameter int DROP_FILTER  = 1024,
    parameter int MAX_RETRY    = 8
) (
    input  logic               clk_50m,
    input  logic               sys_rst,
    input  logic               enable,
    input  logic               retry_req,
    input  logic               port_initialized,
    input  logic               link_initialized,
    output logic               srio_core_rst,
    output logic               fiber_sw_rst,
    output logic               link_up,
    output logic               link_fail,
`ifdef SRIO_SUP_STATS_EN
    output logic [DROP_CNT_W-1:0] link_drop_cnt,
`endif
    output logic [RETRY_W-1:0] retry_cnt
);

    localparam int RST_W  = clog2(RST_HOLD);
    localparam int WAIT_W = clog2(LINK_TIMEOUT);
    localparam int DROP_W = clog2(DROP_FILTER);

    localparam logic [RST_W-1:0]   RST_LAST  = RST_W'(RST_HOLD - 1);
    localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(LINK_TIMEOUT - 1);
    localparam logic [DROP_W-1:0]  DROP_LAST = DROP_W'(DROP_FILTER - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    (* ASYNC_REG = "TRUE" *) logic [1:0] port_sync;
    (* ASYNC_REG = "TRUE" *) logic [1:0] link_sync;

    sup_state_t         state, state_nx;
    logic [RETRY_W-1:0] retry_nx, retry_inc;
    logic [RST_W-1:0]   rst_tmr;
    logic [WAIT_W-1:0]  wait_tmr;
    logic [DROP_W-1:0]  drop_tmr;
    logic               lnk_ok;

    always_ff @(posedge clk_50m) begin
        if (sys_rst) begin
            port_sync <= '0;
            link_sync <= '0;
        end else begin
            port_sync <= {port_sync[0], port_initialized};
            link_sync <= {link_sync[0], link_initialized};
        end
    end

    assign lnk_ok = port_sync[1] & link_sync[1];

    // enable low overrides everything; a link seen on the timeout cycle still counts as up.
    always_comb begin
        state_nx  = state;
        retry_nx  = retry_cnt;
        retry_inc = (retry_cnt == RETRY_MAX) ? retry_cnt : retry_cnt + RETRY_W'(1);
        if (!enable) begin
            state_nx = S_OFF;
        end else begin
            case (state)
                S_OFF: begin
                    state_nx = S_RST;
                    retry_nx = '0;
                end
                S_RST: begin
                    if (rst_tmr == RST_LAST) state_nx = S_WAIT;
                end
                S_WAIT: begin
                    if (lnk_ok) begin
                        state_nx = S_UP;
                        retry_nx = '0;
                    end else if (wait_tmr == WAIT_LAST) begin
                        retry_nx = retry_inc;
                        state_nx = (retry_inc == RETRY_MAX) ? S_FAIL : S_RST;
                    end
                end
                S_UP: begin
                    if (!lnk_ok && drop_tmr == DROP_LAST) state_nx = S_RST;
                end
                S_FAIL: begin
                    if (retry_req) begin
                        state_nx = S_RST;
                        retry_nx = '0;
                    end
                end
                default: state_nx = S_OFF;
            endcase
        end
    end

    // Timers restart whenever their state is entered; outputs decode from the next state.
    always_ff @(posedge clk_50m) begin
        if (sys_rst) begin
            state         <= S_OFF;
            retry_cnt     <= '0;
            rst_tmr       <= '0;
            wait_tmr      <= '0;
            drop_tmr      <= '0;
            srio_core_rst <= 1'b1;
            fiber_sw_rst  <= 1'b0;
            link_up       <= 1'b0;
            link_fail     <= 1'b0;
        end else begin
            state         <= state_nx;
            retry_cnt     <= retry_nx;
            rst_tmr       <= (state == S_RST && state_nx == S_RST) ? rst_tmr + RST_W'(1) : '0;
            wait_tmr      <= (state == S_WAIT && state_nx == S_WAIT) ? wait_tmr + WAIT_W'(1) : '0;
            drop_tmr      <= (state == S_UP && state_nx == S_UP && !lnk_ok) ? drop_tmr + DROP_W'(1) : '0;
            srio_core_rst <= (state_nx == S_OFF) || (state_nx == S_RST) || (state_nx == S_FAIL);
            fiber_sw_rst  <= (state_nx == S_RST);
            link_up       <= (state_nx == S_UP);
            link_fail     <= (state_nx == S_FAIL);
        end
    end

`ifdef SRIO_SUP_STATS_EN
    // Only a filtered drop moves S_UP straight to S_RST; enable loss goes to S_OFF instead.
    always_ff @(posedge clk_50m) begin
        if (sys_rst) begin
            link_drop_cnt <= '0;
        end else if (state == S_UP && state_nx == S_RST && link_drop_cnt != '1) begin
            link_drop_cnt <= link_drop_cnt + DROP_CNT_W'(1);
        end
    end
`endif

endmodule

// File: rtl/srio_link_supervisor.sv
// Multi-channel SRIO link supervisor: one independent srio_link_sup_ch per channel.
// Optional SRIO_SUP_STATS_EN exposes per-channel filtered link-drop counters.
module srio_link_supervisor
    import srio_sup_pkg::*;
#(
    parameter int SRIO_CH_NUM  = 12,
    parameter int RST_HOLD     = 64,
    parameter int LINK_TIMEOUT = 50000000,
    parameter int DROP_FILTER  = 1024,
    parameter int MAX_RETRY    = 8
) (
    input  logic                           clk_50m,
    input  logic                           sys_rst,
    input  logic [SRIO_CH_NUM-1:0]         enable,
    input  logic [SRIO_CH_NUM-1:0]         retry_req,
    input  logic [SRIO_CH_NUM-1:0]         port_initialized,
    input  logic [SRIO_CH_NUM-1:0]         link_initialized,
    output logic [SRIO_CH_NUM-1:0]         srio_core_rst,
    output logic [SRIO_CH_NUM-1:0]         fiber_sw_rst,
    output logic [SRIO_CH_NUM-1:0]         link_up,
    output logic [SRIO_CH_NUM-1:0]         link_fail,
`ifdef SRIO_SUP_STATS_EN
    output logic [SRIO_CH_NUM*DROP_CNT_W-1:0] link_drop_cnt,
`endif
    output logic [SRIO_CH_NUM*RETRY_W-1:0] retry_cnt
);

    for (genvar i = 0; i < SRIO_CH_NUM; i++) begin : g_ch
        srio_link_sup_ch #(
            .RST_HOLD     (RST_HOLD),
            .LINK_TIMEOUT (LINK_TIMEOUT),
            .DROP_FILTER  (DROP_FILTER),
            .MAX_RETRY    (MAX_RETRY)
        ) u_ch (
            .clk_50m          (clk_50m),
            .sys_rst          (sys_rst),
            .enable           (enable[i]),
            .retry_req        (retry_req[i]),
            .port_initialized (port_initialized[i]),
            .link_initialized (link_initialized[i]),
            .srio_core_rst    (srio_core_rst[i]),
            .fiber_sw_rst     (fiber_sw_rst[i]),
            .link_up          (link_up[i]),
            .link_fail        (link_fail[i]),
`ifdef SRIO_SUP_STATS_EN
            .link_drop_cnt    (link_drop_cnt[DROP_CNT_W*i +: DROP_CNT_W]),
`endif
            .retry_cnt        (retry_cnt[RETRY_W*i +: RETRY_W])
        );
    end

endmodule

// File: tb/tb_srio_link_supervisor.sv
// Directed bench for srio_link_supervisor with short timers; stats checks follow SRIO_SUP_STATS_EN.
module tb_srio_link_supervisor;

    localparam int CH = 4;

    logic            clk_50m = 1'b0;
    logic            sys_rst;
    logic [CH-1:0]   enable, retry_req, port_initialized, link_initialized;
    logic [CH-1:0]   srio_core_rst, fiber_sw_rst, link_up, link_fail;
    logic [CH*4-1:0] retry_cnt;
`ifdef SRIO_SUP_STATS_EN
    logic [CH*8-1:0] link_drop_cnt;
`endif

    int checks = 0;
    int errors = 0;

    srio_link_supervisor #(
        .SRIO_CH_NUM  (CH),
        .RST_HOLD     (4),
        .LINK_TIMEOUT (100),
        .DROP_FILTER  (8),
        .MAX_RETRY    (3)
    ) dut (
        .clk_50m          (clk_50m),
        .sys_rst          (sys_rst),
        .enable           (enable),
        .retry_req        (retry_req),
        .port_initialized (port_initialized),
        .link_initialized (link_initialized),
        .srio_core_rst    (srio_core_rst),
        .fiber_sw_rst     (fiber_sw_rst),
        .link_up          (link_up),
        .link_fail        (link_fail),
`ifdef SRIO_SUP_STATS_EN
        .link_drop_cnt    (link_drop_cnt),
`endif
        .retry_cnt        (retry_cnt)
    );

    always #5 clk_50m = ~clk_50m;

    task automatic tick(input int n);
        repeat (n) @(posedge clk_50m);
        #1;
    endtask

    task automatic applyStimulus(input logic [CH-1:0] en, input logic [CH-1:0] rq,
                                 input logic [CH-1:0] pi, input logic [CH-1:0] li);
        enable           = en;
        retry_req        = rq;
        port_initialized = pi;
        link_initialized = li;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        // Reset with every link reporting ready.
        sys_rst = 1'b1;
        applyStimulus(4'b0000, 4'b0000, 4'b1111, 4'b1111);
        tick(3);
        checkOutput("rst_core", 32'(srio_core_rst), 32'hF);
        checkOutput("rst_fiber", 32'(fiber_sw_rst), 32'h0);
        checkOutput("rst_link_up", 32'(link_up), 32'h0);
        checkOutput("rst_link_fail", 32'(link_fail), 32'h0);
        checkOutput("rst_retry", 32'(retry_cnt), 32'h0);
`ifdef SRIO_SUP_STATS_EN
        checkOutput("rst_drop_cnt", 32'(link_drop_cnt), 32'h0);
`endif

        // Bring-up of ch0: 4 cycles of fiber reset, then link up one S_WAIT cycle later.
        sys_rst = 1'b0;
        applyStimulus(4'b0001, 4'b0000, 4'b1111, 4'b1111);
        tick(1);
        checkOutput("rst_entry_core", 32'(srio_core_rst), 32'hF);
        checkOutput("rst_entry_fiber", 32'(fiber_sw_rst), 32'h1);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            checkOutput("rst_hold_fiber", 32'(fiber_sw_rst), 32'h1);
        end
        tick(1);
        checkOutput("wait_entry_fiber", 32'(fiber_sw_rst), 32'h0);
        checkOutput("wait_entry_core", 32'(srio_core_rst), 32'hE);
        checkOutput("wait_entry_up", 32'(link_up), 32'h0);
        tick(1);
        checkOutput("up_link_up", 32'(link_up), 32'h1);
        checkOutput("up_core", 32'(srio_core_rst), 32'hE);
        checkOutput("up_retry", 32'(retry_cnt), 32'h0);

        // A 7-cycle loss is filtered out.
        applyStimulus(4'b0001, 4'b0000, 4'b1111, 4'b1110);
        tick(7);
        applyStimulus(4'b0001, 4'b0000, 4'b1111, 4'b1111);
        for (int i = 0; i < 6; i++) begin
            tick(1);
            checkOutput("glitch_hold_up", 32'(link_up), 32'h1);
        end

        // A sustained loss drops to S_RST on the 8th lost cycle.
        applyStimulus(4'b0001, 4'b0000, 4'b1111, 4'b1110);
        tick(9);
        checkOutput("drop_filter_up", 32'(link_up), 32'h1);
        tick(1);
        checkOutput("drop_to_rst_up", 32'(link_up), 32'h0);
        checkOutput("drop_to_rst_fiber", 32'(fiber_sw_rst), 32'h1);
`ifdef SRIO_SUP_STATS_EN
        checkOutput("drop_cnt_one", 32'(link_drop_cnt), 32'h1);
`endif
        applyStimulus(4'b0001, 4'b0000, 4'b1111, 4'b1111);
        tick(3);
        checkOutput("drop_fiber_hold", 32'(fiber_sw_rst), 32'h1);
        tick(1);
        checkOutput("drop_fiber_end", 32'(fiber_sw_rst), 32'h0);
        tick(1);
        checkOutput("relink_up", 32'(link_up), 32'h1);

        // Disable, then re-enable with the link absent: three timeouts to S_FAIL.
        applyStimulus(4'b0000, 4'b0000, 4'b1111, 4'b1110);
        tick(1);
        checkOutput("disable_core", 32'(srio_core_rst), 32'hF);
        checkOutput("disable_up", 32'(link_up), 32'h0);
        applyStimulus(4'b0001, 4'b0000, 4'b1111, 4'b1110);
        tick(1);
        checkOutput("restart_fiber", 32'(fiber_sw_rst), 32'h1);
        tick(4);
        checkOutput("restart_wait_fiber", 32'(fiber_sw_rst), 32'h0);
        for (int k = 1; k <= 3; k++) begin
            tick(99);
            checkOutput("wait_no_timeout", 32'(retry_cnt), 32'(k - 1));
            tick(1);
            checkOutput("timeout_step", 32'(retry_cnt), 32'(k));
            if (k < 3) begin
                checkOutput("timeout_fiber", 32'(fiber_sw_rst), 32'h1);
                tick(4);
            end
        end
        checkOutput("fail_flag", 32'(link_fail), 32'h1);
        checkOutput("fail_core", 32'(srio_core_rst), 32'hF);
        checkOutput("fail_fiber", 32'(fiber_sw_rst), 32'h0);
        tick(5);
        checkOutput("fail_stays", 32'(link_fail), 32'h1);
        checkOutput("fail_retry_sat", 32'(retry_cnt), 32'h3);

        // retry_req pulse restarts from S_RST with a clean count.
        applyStimulus(4'b0001, 4'b0001, 4'b1111, 4'b1110);
        tick(1);
        applyStimulus(4'b0001, 4'b0000, 4'b1111, 4'b1110);
        checkOutput("retry_req_cnt", 32'(retry_cnt), 32'h0);
        checkOutput("retry_req_fiber", 32'(fiber_sw_rst), 32'h1);
        checkOutput("retry_req_fail", 32'(link_fail), 32'h0);

        // Two more timeouts, then drop enable mid-S_WAIT.
        tick(104);
        checkOutput("retry_one", 32'(retry_cnt), 32'h1);
        tick(104);
        checkOutput("retry_two", 32'(retry_cnt), 32'h2);
        tick(14);
        applyStimulus(4'b0000, 4'b0000, 4'b1111, 4'b1110);
        tick(1);
        checkOutput("enable_drop_core", 32'(srio_core_rst), 32'hF);
        checkOutput("enable_drop_fiber", 32'(fiber_sw_rst), 32'h0);
        applyStimulus(4'b0001, 4'b0000, 4'b1111, 4'b1110);
        tick(1);
        checkOutput("reenable_retry", 32'(retry_cnt), 32'h0);
        checkOutput("reenable_fiber", 32'(fiber_sw_rst), 32'h1);

        // Link becomes valid exactly on the timer=99 cycle: link wins.
        tick(101);
        applyStimulus(4'b0001, 4'b0000, 4'b1111, 4'b1111);
        tick(2);
        checkOutput("pre_race_up", 32'(link_up), 32'h0);
        checkOutput("pre_race_retry", 32'(retry_cnt), 32'h0);
        tick(1);
        checkOutput("race_up", 32'(link_up), 32'h1);
        checkOutput("race_retry", 32'(retry_cnt), 32'h0);
        checkOutput("race_fiber", 32'(fiber_sw_rst), 32'h0);

        // sys_rst while up returns everything to reset values on the next edge.
        tick(3);
        sys_rst = 1'b1;
        tick(1);
        checkOutput("midrst_core", 32'(srio_core_rst), 32'hF);
        checkOutput("midrst_fiber", 32'(fiber_sw_rst), 32'h0);
        checkOutput("midrst_up", 32'(link_up), 32'h0);
        checkOutput("midrst_fail", 32'(link_fail), 32'h0);
        checkOutput("midrst_retry", 32'(retry_cnt), 32'h0);
`ifdef SRIO_SUP_STATS_EN
        checkOutput("midrst_drop_cnt", 32'(link_drop_cnt), 32'h0);
`endif
        sys_rst = 1'b0;
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000);
        tick(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/srio_link_supervisor.md
Name: srio_link_supervisor

Overview:
Per-channel link bring-up and recovery controller for the multi-channel SRIO 1x wrapper. Sequences each channel's core reset and fiber soft reset, then waits for port/link initialization with a timeout. Monitors established links with a glitch filter and retries on failure up to a limit. Sits in the clk_50m domain. Drives the wrapper's srio_core_rst/fiber_sw_rst vectors and consumes its port_initialized/link_initialized status.

Parameters:
SRIO_CH_NUM, 12, number of supervised channels
RST_HOLD, 64, clk_50m cycles the core/fiber reset is held per attempt (>=2)
LINK_TIMEOUT, 50000000, cycles allowed in S_WAIT for link before retry (1 s at 50 MHz)
DROP_FILTER, 1024, consecutive link-lost cycles in S_UP before recovery
MAX_RETRY, 8, consecutive failed attempts before S_FAIL (1..15)

Ports:
clk_50m  in  1  sole clock
sys_rst  in  1  synchronous reset, active high
enable  in  SRIO_CH_NUM  per-channel supervisor enable; low forces channel off
retry_req  in  SRIO_CH_NUM  single-cycle pulse; restarts a channel from S_FAIL
port_initialized  in  SRIO_CH_NUM  from wrapper, asynchronous (log_clk domain)
link_initialized  in  SRIO_CH_NUM  from wrapper, asynchronous (log_clk domain)
srio_core_rst  out  SRIO_CH_NUM  core reset to wrapper, active high
fiber_sw_rst  out  SRIO_CH_NUM  fiber soft reset to wrapper, active high
link_up  out  SRIO_CH_NUM  channel in S_UP
link_fail  out  SRIO_CH_NUM  channel in S_FAIL
retry_cnt  out  SRIO_CH_NUM*4  per-channel consecutive failed-attempt count; channel i at [4*i +: 4]

Behaviour:
- One clock, clk_50m. Reset is synchronous and active-high via sys_rst.
- Channels are fully independent. No shared state except clock and reset.
- Each channel synchronizes port_initialized and link_initialized with a 2-flop chain (ASYNC_REG).
- lnk_ok = synced port_initialized AND synced link_initialized. Input-to-lnk_ok latency: 2 cycles.
- All outputs are registered and decoded from the next state, so they change in the same cycle the state register updates.
- Reset values: state S_OFF; srio_core_rst=1; fiber_sw_rst=0; link_up=0; link_fail=0; retry_cnt=0; timers=0.
- Per-channel FSM:
  - S_OFF: core_rst=1, fiber=0. If enable=1, go to S_RST and clear retry_cnt.
  - S_RST: core_rst=1, fiber=1. Count RST_HOLD cycles (exactly RST_HOLD cycles in state), then go to S_WAIT.
  - S_WAIT: core_rst=0, fiber=0. Timer counts up from 0.
    - If lnk_ok=1, go to S_UP.
    - Else, when timer = LINK_TIMEOUT-1, increment retry_cnt. If the new value = MAX_RETRY, go to S_FAIL; otherwise go to S_RST.
    - If lnk_ok and timeout occur in the same cycle, lnk_ok wins.
  - S_UP: link_up=1. retry_cnt cleared on entry.
    - Drop counter increments each cycle lnk_ok=0 and resets to 0 on any cycle lnk_ok=1.
    - When the drop counter reaches DROP_FILTER-1, go to S_RST.
    - A loss shorter than DROP_FILTER cycles has no effect.
  - S_FAIL: link_fail=1, core_rst=1, fiber=0. retry_req=1 clears retry_cnt and goes to S_RST. retry_req is ignored in all other states.
- enable=0 in any state forces S_OFF on the next edge. enable has priority over all transitions except sys_rst.
- enable re-asserted mid-sequence always restarts from S_RST with retry_cnt=0.
- Timer widths are $clog2 of the respective parameter. The LINK_TIMEOUT timer is 26 bits at default.
- retry_cnt saturates at MAX_RETRY and never wraps.
- sys_rst asserted mid-operation returns every channel to S_OFF in one cycle. srio_core_rst is asserted on that same edge.

Optional Feature:
Macro SRIO_SUP_STATS_EN.
- Defined: adds output port link_drop_cnt (SRIO_CH_NUM*8), channel i at [8*i +: 8].
  - Counts S_UP to S_RST filtered drops, saturating at 255.
  - Cleared only by sys_rst; survives enable toggles.
- Undefined: port and counters absent; all other behaviour identical.

Decomposition:
- Package srio_sup_pkg holds:
  - the state enum (S_OFF, S_RST, S_WAIT, S_UP, S_FAIL), 3-bit encoding;
  - RETRY_W=4 and DROP_CNT_W=8 constants;
  - a clog2 helper function.
- Sub-module srio_link_sup_ch: one-channel synchronizer, FSM and timers.
- The top replicates it SRIO_CH_NUM times in a generate loop and packs the vectors.

Test Plan (RST_HOLD=4, LINK_TIMEOUT=100, DROP_FILTER=8, MAX_RETRY=3, SRIO_CH_NUM=4):
- sys_rst for 3 cycles, then enable=4'b0001, link inputs high from the start -> ch0:
  - srio_core_rst/fiber_sw_rst high exactly 4 cycles after S_RST entry;
  - link_up=1 at the first S_WAIT cycle with lnk_ok=1 (2-cycle sync);
  - ch1-3 hold core_rst=1, link_up=0.
- ch0 enabled, link inputs never high -> three 100-cycle timeouts; retry_cnt steps 1, 2, 3; link_fail=1 with core_rst=1; a retry_req pulse returns to S_RST with retry_cnt=0.
- ch0 in S_UP, link_initialized low for 7 cycles then high -> link_up stays 1.
- ch0 in S_UP, link_initialized low for 8+ cycles -> S_RST; fiber_sw_rst pulses 4 cycles. With SRIO_SUP_STATS_EN, link_drop_cnt[7:0]=1.
- enable dropped mid-S_WAIT with retry_cnt=2 -> next cycle S_OFF, core_rst=1; re-enable gives retry_cnt=0.
- lnk_ok rising in the same cycle as timer=99 -> S_UP, retry_cnt unchanged. Mid-S_UP sys_rst -> all outputs at reset values on the next edge.
